// File: rtl/audio_vis_pkg.sv
// Shared types and helpers for the audio peak meter and the visualisation
// modules that consume its published peaks.
package audio_vis_pkg;

    typedef logic signed [15:0] audio_t;
    typedef logic        [14:0] peak_t;

    localparam peak_t PEAK_MAX = 15'h7FFF;

    // Magnitude of a signed sample, clamped so that -32768 lands on PEAK_MAX.
    function automatic peak_t absSat(input audio_t x);
        logic [15:0] raw;
        logic [15:0] mag;
        raw = x;
        mag = raw[15] ? (~raw + 16'd1) : raw;
        return mag[15] ? PEAK_MAX : mag[14:0];
    endfunction

    // Width of the hold counter; at least one bit so HOLD_LEN=0 still elaborates.
    function automatic int holdWidth(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/audio_peak_meter_if.sv
// Sample stream in, published peaks and frame strobe out.
interface audio_peak_meter_if;
    import audio_vis_pkg::*;

    logic   iSTB;
    audio_t iL;
    audio_t iR;
    peak_t  oPL;
    peak_t  oPR;
    logic   oFS;

    modport master (
        output iSTB, iL, iR,
        input  oPL, oPR, oFS
    );

    modport slave (
        input  iSTB, iL, iR,
        output oPL, oPR, oFS
    );

endinterface

// File: rtl/audio_peak_meter_peak_channel.sv
// One channel of the peak meter: rectify, window max, and the displayed peak.
// PEAK_DECAY_EN adds peak-hold and gradual decay; without it the displayed
// value is simply the maximum of the last completed frame.
module peak_channel
    import audio_vis_pkg::*;
#(
    parameter int HOLD_LEN    = 4,
    parameter int DECAY_SHIFT = 4
) (
    input  logic   iCLK,
    input  logic   iRAND_RST,
    input  audio_t sample_i,
    input  logic   stb_i,
    input  logic   stbS1_i,
    input  logic   last_i,
    input  logic   pub_i,
    output peak_t  d_o
);

    peak_t a_q;
    peak_t w_q;
    peak_t wLat_q;
    peak_t disp_q;
    peak_t disp_d;
    peak_t wNext;

    assign wNext = (a_q > w_q) ? a_q : w_q;
    assign d_o   = disp_q;

    // Rectified magnitude of each accepted sample.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            a_q <= '0;
        end else if (stb_i) begin
            a_q <= absSat(sample_i);
        end
    end

    // Running window max; the closing sample is folded in before latching.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            w_q    <= '0;
            wLat_q <= '0;
        end else if (stbS1_i) begin
            if (last_i) begin
                wLat_q <= wNext;
                w_q    <= '0;
            end else begin
                w_q <= wNext;
            end
        end
    end

`ifdef PEAK_DECAY_EN
    localparam int HW = holdWidth(HOLD_LEN);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_LEN);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    peak_t         step;
    peak_t         decayed;

    // Decay step is a fraction of the displayed value but never below one.
    always_comb begin
        step = disp_q >> DECAY_SHIFT;
        if (step == '0) begin
            step = 15'd1;
        end
        decayed = (disp_q > step) ? (disp_q - step) : '0;
    end

    // New peaks load immediately and arm the hold; otherwise hold, then decay.
    always_comb begin
        disp_d = disp_q;
        hold_d = hold_q;
        if (pub_i) begin
            if (wLat_q >= disp_q) begin
                disp_d = wLat_q;
                hold_d = HOLD_LOAD;
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else begin
                disp_d = (wLat_q > decayed) ? wLat_q : decayed;
            end
        end
    end

    // Displayed peak and hold counter.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            disp_q <= '0;
            hold_q <= '0;
        end else begin
            disp_q <= disp_d;
            hold_q <= hold_d;
        end
    end
`else
    // Without hold/decay each publish shows the plain frame maximum.
    always_comb begin
        disp_d = disp_q;
        if (pub_i) begin
            disp_d = wLat_q;
        end
    end

    // Displayed peak.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end
`endif

endmodule

// File: rtl/audio_peak_meter.sv
// Stereo audio peak meter: frames FRAME_LEN accepted samples, publishes a
// 15-bit peak per channel and a one-cycle frame strobe oFS.
// Optional feature macro: PEAK_DECAY_EN (peak-hold and decay).
module audio_peak_meter
    import audio_vis_pkg::*;
#(
    parameter int FRAME_LEN   = 800,
    parameter int HOLD_LEN    = 4,
    parameter int DECAY_SHIFT = 4
) (
    input  logic iCLK,
    input  logic iRAND_RST,
    audio_peak_meter_if.slave bus
);

    typedef enum logic [0:0] {
        ACC = 1'b0,
        PUB = 1'b1
    } meterState_t;

    localparam logic [15:0] FC_LAST = 16'(FRAME_LEN - 1);

    if (FRAME_LEN < 1 || FRAME_LEN > 65535 || HOLD_LEN < 0 || DECAY_SHIFT < 0) begin : gParamCheck
        $error("audio_peak_meter: parameter out of range");
    end

    logic [15:0] fc_q;
    logic [15:0] fc_d;
    logic        last_q;
    logic        last_d;
    logic        stbS1_q;
    logic        fs_q;
    meterState_t state_q;
    meterState_t state_d;
    logic        pubTrig;
    logic        pubNow;
    peak_t       dL;
    peak_t       dR;

    assign pubTrig = stbS1_q && last_q;
    assign pubNow  = (state_q == PUB);

    // Frame position advances per accepted sample and flags the closing one.
    always_comb begin
        fc_d   = fc_q;
        last_d = 1'b0;
        if (bus.iSTB) begin
            last_d = (fc_q == FC_LAST);
            fc_d   = last_d ? 16'd0 : (fc_q + 16'd1);
        end
    end

    // Frame counter and the stage-1 strobe/last pipeline.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            fc_q    <= '0;
            last_q  <= 1'b0;
            stbS1_q <= 1'b0;
        end else begin
            fc_q    <= fc_d;
            last_q  <= last_d;
            stbS1_q <= bus.iSTB;
        end
    end

    // PUB is entered for one cycle whenever a frame closes, back-to-back if needed.
    always_comb begin
        state_d = ACC;
        case (state_q)
            ACC:     state_d = pubTrig ? PUB : ACC;
            PUB:     state_d = pubTrig ? PUB : ACC;
            default: state_d = ACC;
        endcase
    end

    // FSM state register and the frame strobe that follows each publish.
    always_ff @(posedge iCLK or negedge iRAND_RST) begin
        if (!iRAND_RST) begin
            state_q <= ACC;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fs_q    <= pubNow;
        end
    end

    peak_channel #(
        .HOLD_LEN    (HOLD_LEN),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) uChanL (
        .iCLK      (iCLK),
        .iRAND_RST (iRAND_RST),
        .sample_i  (bus.iL),
        .stb_i     (bus.iSTB),
        .stbS1_i   (stbS1_q),
        .last_i    (last_q),
        .pub_i     (pubNow),
        .d_o       (dL)
    );

    peak_channel #(
        .HOLD_LEN    (HOLD_LEN),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) uChanR (
        .iCLK      (iCLK),
        .iRAND_RST (iRAND_RST),
        .sample_i  (bus.iR),
        .stb_i     (bus.iSTB),
        .stbS1_i   (stbS1_q),
        .last_i    (last_q),
        .pub_i     (pubNow),
        .d_o       (dR)
    );

    assign bus.oPL = dL;
    assign bus.oPR = dR;
    assign bus.oFS = fs_q;

endmodule
